sdram_avalon_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares the single SDRAM controller slave port (16-bit, 25-bit word address, 64 MB) between two masters, e.g. the Nios II data master and a DMA/video reader. It serialises commands, tracks outstanding reads with a tag FIFO so that pipelined `readdatavalid` returns reach the requester that issued them, and flags protocol violations. It sits in the SDRAM clock domain, between the masters and the `sdram` controller slave.

---
 rtl/sdram_avalon_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_avalon_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_avalon_arbiter
// Brief    : Two-master Avalon-MM arbiter in front of a single SDRAM
//            controller slave. Serialises commands, tags outstanding reads
//            so pipelined returns reach the issuing master, and raises
//            sticky protocol-error flags.
// Config   : define SDRAM_ARB_FIXED_PRIO_EN to make m0 win every tie
//            (round-robin otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module sdram_avalon_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_orphan,
  output logic                err_rw
);

  localparam int c_PTR_W = $clog2(MAX_PEND);
  localparam int c_CNT_W = $clog2(MAX_PEND) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY0 = 2'd1,
    S_BUSY1 = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last;
  logic [c_CNT_W-1:0]   r_pend_cnt;
  logic [MAX_PEND-1:0]  r_tag_mem;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;

  logic w_room;
  logic w_elig0;
  logic w_elig1;
  logic w_pick1;
  logic w_accept;
  logic w_grant_id;
  logic w_acc_rd;
  logic w_rw;
  logic w_push;
  logic w_pop;
  logic w_pop_id;

  assign w_room = (r_pend_cnt < c_CNT_W'(MAX_PEND));

  // A read+write request is executed as a read, so it must obey the read
  // room check; otherwise it could push into a full tag FIFO.
  assign w_elig0 = m0_read ? w_room : m0_write;
  assign w_elig1 = m1_read ? w_room : m1_write;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // m0 wins every tie; r_last keeps tracking but does not steer the choice
  assign w_pick1 = w_elig1 & ~w_elig0;
`else
  // on a tie grant the master not served last (r_last=1 means m1 was last)
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state, slave-side command mux and master stalls
  always_comb begin
    w_state_nxt    = r_state;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    w_accept       = 1'b0;
    w_grant_id     = 1'b0;
    w_acc_rd       = 1'b0;
    w_rw           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_elig0 | w_elig1) w_state_nxt = w_pick1 ? S_BUSY1 : S_BUSY0;
      end
      S_BUSY0: begin
        s_address    = m0_address;
        s_read       = m0_read;
        s_write      = m0_write & ~m0_read;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
        w_rw         = m0_read & m0_write;
        if (!s_waitrequest) begin
          m0_waitrequest = 1'b0;
          w_accept       = 1'b1;
          w_acc_rd       = m0_read;
          w_state_nxt    = S_IDLE;
        end
      end
      S_BUSY1: begin
        s_address    = m1_address;
        s_read       = m1_read;
        s_write      = m1_write & ~m1_read;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
        w_rw         = m1_read & m1_write;
        w_grant_id   = 1'b1;
        if (!s_waitrequest) begin
          m1_waitrequest = 1'b0;
          w_accept       = 1'b1;
          w_acc_rd       = m1_read;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_push   = w_accept & w_acc_rd;
  assign w_pop    = s_readdatavalid & (r_pend_cnt != '0);
  assign w_pop_id = r_tag_mem[r_rd_ptr];

  // remember who was served last for the round-robin tie break
  always_ff @(posedge clk) begin
    if (reset)         r_last <= 1'b1;
    else if (w_accept) r_last <= w_grant_id;
  end

  // read tag FIFO: requester ID per outstanding read, in issue order
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_mem  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_push) begin
        r_tag_mem[r_wr_ptr] <= w_grant_id;
        r_wr_ptr            <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_push && !w_pop)      r_pend_cnt <= r_pend_cnt + c_CNT_W'(1);
      else if (!w_push && w_pop) r_pend_cnt <= r_pend_cnt - c_CNT_W'(1);
    end
  end

  // register returned data to both masters; valid goes to the tagged one
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
    end else begin
      m0_readdatavalid <= w_pop & ~w_pop_id;
      m1_readdatavalid <= w_pop &  w_pop_id;
      if (w_pop) begin
        m0_readdata <= s_readdata;
        m1_readdata <= s_readdata;
      end
    end
  end

  // sticky protocol-error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_orphan <= 1'b0;
      err_rw     <= 1'b0;
    end else begin
      if (s_readdatavalid && r_pend_cnt == '0) err_orphan <= 1'b1;
      if (w_rw)                                err_rw     <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_avalon_arbiter
// Brief    : Self-checking bench for sdram_avalon_arbiter. Masters replay
//            command queues Avalon-style, an SDRAM slave model returns reads
//            in order, and a scoreboard checks commands and return routing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_avalon_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_waitrequest = 1'b0;
  logic [DATA_W-1:0] s_readdata = '0;
  logic              s_readdatavalid = 1'b0;
  logic              err_orphan, err_rw;

  always #5 clk = ~clk;

  sdram_avalon_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(8)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .err_orphan(err_orphan), .err_rw(err_rw)
  );

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;
  typedef struct { int due; logic who; logic [DATA_W-1:0] data; } slv_t;
  typedef struct { int cyc; logic who; } ret_t;

  cmd_t              mq0[$], mq1[$];
  logic [DATA_W-1:0] exp0[$], exp1[$];
  slv_t              slv_q[$];
  ret_t              ret_exp[$];
  logic              grant_log[$];
  int  acc_cnt0 = 0, acc_cnt1 = 0, cyc = 0, last_due = 0;
  int  lat_min = 3, lat_max = 3;
  int  total = 0, bad = 0;
  logic pres0 = 0, pres1 = 0, hold1 = 0, gaps = 0;
  logic sw_force = 0, sw_rand = 0, ret_en = 1, force_orphan = 0;

  // SDRAM contents as seen by the slave model: a fixed function of address
  function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ {a[24:17], 8'h5A} ^ 16'h1234;
  endfunction

  function automatic cmd_t mk(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.wdata = d; c.be = be;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // an accepted command must be the granted master's current request
  task automatic accept(input logic who);
    cmd_t c;
    slv_t s;
    logic p;
    p = who ? pres1 : pres0;
    chk("acc_presenting", 32'(p), 32'(1));
    chk("acc_s_waitrequest", 32'(s_waitrequest), 32'(0));
    if (p) begin
      c = who ? mq1.pop_front() : mq0.pop_front();
      chk("s_address", 32'(s_address), 32'(c.addr));
      chk("s_read", 32'(s_read), 32'(c.rd));
      chk("s_write", 32'(s_write), 32'(c.wr & ~c.rd));
      chk("s_writedata", 32'(s_writedata), 32'(c.wdata));
      chk("s_byteenable", 32'(s_byteenable), 32'(c.be));
      if (who) begin pres1 = 0; acc_cnt1++; end
      else     begin pres0 = 0; acc_cnt0++; end
      grant_log.push_back(who);
      if (c.rd) begin
        if (who) exp1.push_back(memf(c.addr)); else exp0.push_back(memf(c.addr));
        s.due = cyc + $urandom_range(lat_min, lat_max);
        if (s.due <= last_due) s.due = last_due + 1;
        last_due = s.due;
        s.who = who;
        s.data = memf(s_address);
        slv_q.push_back(s);
      end
    end
  endtask

  task automatic observe();
    logic exp_any, who;
    logic [DATA_W-1:0] d;
    int n;
    if (!m0_waitrequest) begin
      chk("m1_wreq_during_m0_acc", 32'(m1_waitrequest), 32'(1));
      accept(1'b0);
    end else if (!m1_waitrequest) begin
      accept(1'b1);
    end
    exp_any = (ret_exp.size() > 0) && (ret_exp[0].cyc == cyc);
    who = exp_any ? ret_exp[0].who : 1'b0;
    if (exp_any || m0_readdatavalid || m1_readdatavalid) begin
      chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(exp_any && !who));
      chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(exp_any && who));
      if (exp_any) begin
        void'(ret_exp.pop_front());
        n = who ? exp1.size() : exp0.size();
        chk("ret_has_expect", 32'(n != 0), 32'(1));
        if (n != 0) begin
          d = who ? exp1.pop_front() : exp0.pop_front();
          chk("readdata_target", 32'(who ? m1_readdata : m0_readdata), 32'(d));
          chk("readdata_other", 32'(who ? m0_readdata : m1_readdata), 32'(d));
        end
      end
    end
  endtask

  // one clock: drive inputs just after the edge, observe on the falling edge
  task automatic cycle();
    slv_t s;
    ret_t r;
    @(posedge clk); #1;
    cyc++;
    if (!pres0 && mq0.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) pres0 = 1;
    if (!pres1 && mq1.size() > 0 && !hold1 && !(gaps && $urandom_range(0, 3) == 0)) pres1 = 1;
    if (pres0) begin
      m0_read = mq0[0].rd; m0_write = mq0[0].wr; m0_address = mq0[0].addr;
      m0_writedata = mq0[0].wdata; m0_byteenable = mq0[0].be;
    end else begin
      m0_read = 0; m0_write = 0; m0_address = ADDR_W'($urandom);
      m0_writedata = DATA_W'($urandom); m0_byteenable = BE_W'($urandom);
    end
    if (pres1) begin
      m1_read = mq1[0].rd; m1_write = mq1[0].wr; m1_address = mq1[0].addr;
      m1_writedata = mq1[0].wdata; m1_byteenable = mq1[0].be;
    end else begin
      m1_read = 0; m1_write = 0; m1_address = ADDR_W'($urandom);
      m1_writedata = DATA_W'($urandom); m1_byteenable = BE_W'($urandom);
    end
    s_waitrequest = sw_force ? 1'b1 : (sw_rand ? ($urandom_range(0, 99) < 30) : 1'b0);
    s_readdatavalid = 1'b0;
    s_readdata = DATA_W'($urandom);
    if (force_orphan) begin
      s_readdatavalid = 1'b1;
      force_orphan = 0;
    end else if (ret_en && slv_q.size() > 0 && slv_q[0].due <= cyc) begin
      s = slv_q.pop_front();
      s_readdatavalid = 1'b1;
      s_readdata = s.data;
      r.cyc = cyc + 1;
      r.who = s.who;
      ret_exp.push_back(r);
    end
    @(negedge clk);
    if (!reset) observe();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((mq0.size() > 0 || mq1.size() > 0 || pres0 || pres1 || slv_q.size() > 0 ||
            ret_exp.size() > 0 || exp0.size() > 0 || exp1.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n < budget), 32'(1));
  endtask

  // reset DUT and the shared-reset slave model together
  task automatic do_reset();
    mq0.delete(); mq1.delete(); exp0.delete(); exp1.delete();
    slv_q.delete(); ret_exp.delete(); grant_log.delete();
    pres0 = 0; pres1 = 0; last_due = 0; acc_cnt0 = 0; acc_cnt1 = 0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    int n, b0, b1;
    logic exp_g;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    // reset values
    chk("rst_s_address", 32'(s_address), 32'(0));
    chk("rst_s_read", 32'(s_read), 32'(0));
    chk("rst_s_write", 32'(s_write), 32'(0));
    chk("rst_s_writedata", 32'(s_writedata), 32'(0));
    chk("rst_s_byteenable", 32'(s_byteenable), 32'(0));
    chk("rst_m0_waitrequest", 32'(m0_waitrequest), 32'(1));
    chk("rst_m1_waitrequest", 32'(m1_waitrequest), 32'(1));
    chk("rst_m0_rdv", 32'(m0_readdatavalid), 32'(0));
    chk("rst_m1_rdv", 32'(m1_readdatavalid), 32'(0));
    chk("rst_m0_readdata", 32'(m0_readdata), 32'(0));
    chk("rst_m1_readdata", 32'(m1_readdata), 32'(0));
    chk("rst_err_orphan", 32'(err_orphan), 32'(0));
    chk("rst_err_rw", 32'(err_rw), 32'(0));

    // single m0 write: seen at N, on the slave and accepted at N+1, idle at N+2
    mq0.push_back(mk(1'b0, 1'b1, 25'h0000010, 16'hA5A5, 2'b11));
    cycle();
    chk("t1_n_s_write", 32'(s_write), 32'(0));
    chk("t1_n_m0_wreq", 32'(m0_waitrequest), 32'(1));
    cycle();
    chk("t1_n1_s_write", 32'(s_write), 32'(1));
    chk("t1_n1_m0_wreq", 32'(m0_waitrequest), 32'(0));
    cycle();
    chk("t1_n2_s_write", 32'(s_write), 32'(0));
    chk("t1_n2_m0_wreq", 32'(m0_waitrequest), 32'(1));
    chk("t1_acc", 32'(acc_cnt0), 32'(1));

    // both masters reading continuously, returns 3 cycles after accept
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mq0.push_back(mk(1'b1, 1'b0, ADDR_W'(32'h100 + i), 16'h0, 2'b11));
      mq1.push_back(mk(1'b1, 1'b0, ADDR_W'(32'h1000000 + i), 16'h0, 2'b11));
    end
    drain("t2_drain", 300);
    chk("t2_grants", 32'(grant_log.size()), 32'(12));
    for (int i = 0; i < 12 && i < grant_log.size(); i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      exp_g = (i >= 6);
`else
      exp_g = i[0];
`endif
      chk($sformatf("t2_grant_%0d", i), 32'(grant_log[i]), 32'(exp_g));
    end

    // m1 fills the read FIFO, 9th read stalls while an m0 write still goes
    ret_en = 0;
    b0 = acc_cnt0; b1 = acc_cnt1;
    for (int i = 0; i < 9; i++) mq1.push_back(mk(1'b1, 1'b0, ADDR_W'(32'h0ABC00 + i), 16'h0, 2'b11));
    n = 0;
    while (acc_cnt1 - b1 < 8 && n < 60) begin cycle(); n++; end
    chk("t3_eight_acc", 32'(acc_cnt1 - b1), 32'(8));
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_m1_stall", 32'(m1_waitrequest), 32'(1));
    end
    mq0.push_back(mk(1'b0, 1'b1, 25'h1FFFFFF, 16'h5EED, 2'b01));
    n = 0;
    while (acc_cnt0 == b0 && n < 10) begin cycle(); n++; end
    chk("t3_m0_write_acc", 32'(acc_cnt0 - b0), 32'(1));
    chk("t3_m1_still_8", 32'(acc_cnt1 - b1), 32'(8));
    ret_en = 1;
    n = 0;
    while (acc_cnt1 - b1 < 9 && n < 20) begin cycle(); n++; end
    chk("t3_nine_acc", 32'(acc_cnt1 - b1), 32'(9));
    drain("t3_drain", 200);

    // slave stalls 5 cycles in BUSY0: command stable, m1 not granted
    hold1 = 1; sw_force = 1;
    b1 = acc_cnt1;
    mq0.push_back(mk(1'b0, 1'b1, 25'h0123456, 16'hC3C3, 2'b10));
    mq1.push_back(mk(1'b1, 1'b0, 25'h1ABCDEF, 16'h0, 2'b11));
    cycle();
    hold1 = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_s_write", 32'(s_write), 32'(1));
      chk("t4_s_address", 32'(s_address), 32'(25'h0123456));
      chk("t4_s_writedata", 32'(s_writedata), 32'(16'hC3C3));
      chk("t4_s_byteenable", 32'(s_byteenable), 32'(2'b10));
      chk("t4_m0_wreq", 32'(m0_waitrequest), 32'(1));
      chk("t4_m1_wreq", 32'(m1_waitrequest), 32'(1));
    end
    sw_force = 0;
    cycle();
    chk("t4_m0_acc", 32'(m0_waitrequest), 32'(0));
    chk("t4_m1_not_yet", 32'(acc_cnt1 - b1), 32'(0));
    drain("t4_drain", 100);

    // read and write together: executed as read, err_rw raised
    chk("rw_err_before", 32'(err_rw), 32'(0));
    mq0.push_back(mk(1'b1, 1'b1, 25'h0000777, 16'hFFFF, 2'b11));
    drain("rw_drain", 50);
    chk("rw_err_after", 32'(err_rw), 32'(1));

    // orphan return: flag sticks, nothing delivered
    force_orphan = 1;
    cycle();
    cycle();
    chk("orph_err", 32'(err_orphan), 32'(1));
    chk("orph_m0_rdv", 32'(m0_readdatavalid), 32'(0));
    chk("orph_m1_rdv", 32'(m1_readdatavalid), 32'(0));
    cycle();
    chk("orph_sticky", 32'(err_orphan), 32'(1));

    // reset with three reads outstanding
    ret_en = 0;
    b1 = acc_cnt1;
    for (int i = 0; i < 3; i++) mq1.push_back(mk(1'b1, 1'b0, ADDR_W'(32'h0004000 + i), 16'h0, 2'b11));
    n = 0;
    while (acc_cnt1 - b1 < 3 && n < 30) begin cycle(); n++; end
    chk("rst_mid_three_acc", 32'(acc_cnt1 - b1), 32'(3));
    do_reset();
    chk("rst_mid_pend_cnt", 32'(dut.r_pend_cnt), 32'(0));
    chk("rst_mid_m0_wreq", 32'(m0_waitrequest), 32'(1));
    chk("rst_mid_m1_wreq", 32'(m1_waitrequest), 32'(1));
    chk("rst_mid_err_orphan", 32'(err_orphan), 32'(0));
    chk("rst_mid_err_rw", 32'(err_rw), 32'(0));
    ret_en = 1;
    mq0.push_back(mk(1'b1, 1'b0, 25'h0000042, 16'h0, 2'b11));
    drain("rst_mid_post_read", 50);

    // randomized traffic with random slave stalls and return latency
    do_reset();
    gaps = 1; sw_rand = 1; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 60; i++) begin
      logic r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      mq0.push_back(mk(r0, ~r0, ADDR_W'($urandom), DATA_W'($urandom), BE_W'($urandom_range(1, 3))));
      mq1.push_back(mk(r1, ~r1, ADDR_W'($urandom), DATA_W'($urandom), BE_W'($urandom_range(1, 3))));
    end
    drain("rand_drain", 4000);
    chk("rand_acc0", 32'(acc_cnt0), 32'(60));
    chk("rand_acc1", 32'(acc_cnt1), 32'(60));
    chk("rand_err_orphan", 32'(err_orphan), 32'(0));
    chk("rand_err_rw", 32'(err_rw), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
